piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 8, parallel word width in bits; legal range 2..64.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 parallel_in  input  WIDTH  word to serialise; sampled only on accept.
REQ-006 in_valid  input  1  parallel_in holds a valid word.
REQ-007 in_ready  output  1  block can accept a word this cycle.
REQ-008 en  input  1  shift enable; 0 stalls the frame with all outputs held.
REQ-009 serial_out  output  1  current serial bit; 0 whenever out_valid=0.
REQ-010 out_valid  output  1  serial_out carries a frame bit.
REQ-011 frame_start  output  1  high while the first bit of a frame is presented.
REQ-012 frame_last  output  1  high while the final bit of a frame is presented.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have states IDLE and SHIFT, plus PARITY when the macro in REQ-026 is defined.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; parallel_in is loaded into the shift register and the bit counter is cleared to 0.
REQ-016 Latency: the first bit SHALL appear on serial_out in the cycle after accept, with out_valid=1 and frame_start=1.
REQ-017 In SHIFT, each edge with en=1 SHALL advance one bit and increment the bit counter; with en=0, register, counter and all outputs are held.
REQ-018 in_ready SHALL be high in IDLE, and in SHIFT only when bit counter=WIDTH-1 and en=1 (combinational from en); it is low in all other cycles.
REQ-019 Back-to-back: an accept on the last-bit edge SHALL reload and present the new frame's first bit in the next cycle, with no idle gap.
REQ-020 After the last bit is shifted out with no accept, the FSM SHALL return to IDLE; out_valid=0 and serial_out=0.
REQ-021 in_valid while in_ready=0 SHALL be ignored, and parallel_in changes mid-frame SHALL NOT affect the frame.
REQ-022 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL never exceed WIDTH-1.

Reset
REQ-023 Asserting rst SHALL immediately force IDLE, shift register 0, counter 0, serial_out 0, out_valid 0, frame_start 0, frame_last 0 and busy 0.
REQ-024 Reset mid-frame SHALL discard the frame; no partial bits follow deassertion.
REQ-025 in_ready SHALL be 1 from the first cycle after rst deasserts.

Configuration
REQ-026 With PISO_SERIALIZER_PARITY_EN defined, one extra PARITY bit SHALL follow the data bits; it is even parity (XOR of the accepted word, latched at accept). frame_last moves to the parity bit, en stalls PARITY like SHIFT, and in_ready/back-to-back (REQ-018, REQ-019) apply to the parity cycle.
REQ-027 Without the macro, no PARITY state or parity logic SHALL exist; frames are exactly WIDTH bits.

Structure
REQ-028 Package piso_pkg SHALL hold the FSM state enum typedef and the parity-bit count constant (1 or 0 per macro).
REQ-029 The bit counter with terminal-count output SHALL be a sub-module named piso_bit_cnt; everything else stays in piso_serializer.

Verification
REQ-030 WIDTH=4, MSB_FIRST=1, accept 4'b1011 with en=1: serial_out 1,0,1,1 in the 4 cycles after accept; frame_start on cycle 1, frame_last on cycle 4, then IDLE.
REQ-031 WIDTH=4, MSB_FIRST=0, accept 4'b1100: serial_out 0,0,1,1.
REQ-032 Accept 4'b1011, then hold in_valid with 4'b1100: 8 consecutive out_valid cycles 1,0,1,1,1,1,0,0; in_ready pulses only on the last-bit cycle.
REQ-033 en=0 for 3 cycles after the second bit of 4'b1011: outputs held at 0 for 3 cycles, then 1,1 resume; frame spans 7 cycles.
REQ-034 rst pulsed during the third bit: all outputs 0 at once, in_ready=1 after release, and the next accept of 4'b0110 serialises cleanly.
REQ-035 With PISO_SERIALIZER_PARITY_EN, accept 4'b1011: serial_out 1,0,1,1,1 with frame_last on the fifth bit.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types for the PISO serializer: FSM state enum and parity-bit count.
// PISO_SERIALIZER_PARITY_EN adds the PARITY state and one trailing parity bit.
package piso_pkg;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int PAR_BITS = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_e;
`else
  localparam int PAR_BITS = 0;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
`endif

endpackage

// File: rtl/piso_bit_cnt.sv
// Data-bit counter for the serializer, with terminal-count flag at WIDTH-1.
// Ports: clk, rst (async high), clr_i, inc_i, cnt_o, tc_o.
module piso_bit_cnt #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !tc_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with valid/ready input and framing flags.
// Ports: clk, rst, parallel_in, in_valid, in_ready, en, serial_out,
// out_valid, frame_start, frame_last, busy. Option: PISO_SERIALIZER_PARITY_EN.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] parallel_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  output logic             serial_out,
  output logic             out_valid,
  output logic             frame_start,
  output logic             frame_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] sr_shift;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             load;
  logic             last_bit;
  logic             head;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q, par_d;
`endif

  piso_bit_cnt #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  assign head = MSB_FIRST ? sr_q[WIDTH-1] : sr_q[0];
  assign sr_shift = MSB_FIRST ? {sr_q[WIDTH-2:0], 1'b0}
                              : {1'b0, sr_q[WIDTH-1:1]};

  // Last presented bit of a frame: the only cycle (besides IDLE)
  // where a new word may be taken without a gap.
`ifdef PISO_SERIALIZER_PARITY_EN
  assign last_bit = (state_q == PARITY);
`else
  assign last_bit = (state_q == SHIFT) && tc;
`endif

  assign in_ready = (state_q == IDLE) || (last_bit && en);
  assign load     = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
`ifdef PISO_SERIALIZER_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (load) state_d = SHIFT;
      end
      SHIFT: begin
        if (en) begin
          if (tc) begin
            cnt_clr = 1'b1;
            sr_d    = '0;
`ifdef PISO_SERIALIZER_PARITY_EN
            state_d = PARITY;
`else
            state_d = load ? SHIFT : IDLE;
`endif
          end else begin
            sr_d    = sr_shift;
            cnt_inc = 1'b1;
          end
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY: begin
        if (en) state_d = load ? SHIFT : IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (load) begin
      sr_d    = parallel_in;
      cnt_clr = 1'b1;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_d   = ^parallel_in;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
`ifdef PISO_SERIALIZER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    serial_out  = 1'b0;
    out_valid   = (state_q != IDLE);
    busy        = (state_q != IDLE);
    frame_start = (state_q == SHIFT) && (cnt == '0);
    frame_last  = last_bit;
    unique case (state_q)
      SHIFT:   serial_out = head;
`ifdef PISO_SERIALIZER_PARITY_EN
      PARITY:  serial_out = par_q;
`endif
      default: serial_out = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: MSB-first and LSB-first instances, WIDTH=4,
// directed frames then random traffic against a frame-queue reference model.
module tb_piso_serializer;

  localparam int W = 4;
`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] din;
  logic         vin;
  logic         en;

  logic rdy_m, so_m, ov_m, fs_m, fl_m, bz_m;
  logic rdy_l, so_l, ov_l, fs_l, fl_l, bz_l;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk         (clk),
    .rst         (rst),
    .parallel_in (din),
    .in_valid    (vin),
    .in_ready    (rdy_m),
    .en          (en),
    .serial_out  (so_m),
    .out_valid   (ov_m),
    .frame_start (fs_m),
    .frame_last  (fl_m),
    .busy        (bz_m)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk         (clk),
    .rst         (rst),
    .parallel_in (din),
    .in_valid    (vin),
    .in_ready    (rdy_l),
    .en          (en),
    .serial_out  (so_l),
    .out_valid   (ov_l),
    .frame_start (fs_l),
    .frame_last  (fl_l),
    .busy        (bz_l)
  );

  int total = 0;
  int bad   = 0;

  // Reference: the frame in flight as a list of bits and a read position.
  bit   act;
  int   pos;
  logic bm[NB];
  logic bl[NB];

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic load_frame(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) begin
      bm[i] = w[W-1-i];
      bl[i] = w[i];
    end
`ifdef PISO_SERIALIZER_PARITY_EN
    bm[W] = ^w;
    bl[W] = ^w;
`endif
  endtask

  function automatic logic m_ready();
    return !act || ((pos == NB - 1) && en);
  endfunction

  task automatic check_cycle();
    logic r, bitm, bitl;
    r    = m_ready();
    bitm = act ? bm[pos] : 1'b0;
    bitl = act ? bl[pos] : 1'b0;
    chk("in_ready_msb", rdy_m, r);
    chk("in_ready_lsb", rdy_l, r);
    chk("out_valid", ov_m, act);
    chk("busy", bz_m, act);
    chk("serial_msb", so_m, bitm);
    chk("serial_lsb", so_l, bitl);
    chk("frame_start", fs_m, act && (pos == 0));
    chk("frame_last", fl_m, act && (pos == NB - 1));
    chk("out_valid_lsb", ov_l, act);
    chk("frame_last_lsb", fl_l, act && (pos == NB - 1));
  endtask

  task automatic advance();
    logic acc;
    acc = vin && m_ready();
    if (act && en) begin
      if (pos == NB - 1) act = 1'b0;
      else pos++;
    end
    if (acc) begin
      load_frame(din);
      pos = 0;
      act = 1'b1;
    end
  endtask

  // One clock: inputs applied just after the rising edge, checked on the
  // falling edge, model stepped for the next rising edge.
  task automatic cycle(input logic v, input logic [W-1:0] d, input logic e);
    vin = v;
    din = d;
    en  = e;
    @(negedge clk);
    check_cycle();
    advance();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_so_m"}, so_m, 1'b0);
    chk({tag, "_ov_m"}, ov_m, 1'b0);
    chk({tag, "_fs_m"}, fs_m, 1'b0);
    chk({tag, "_fl_m"}, fl_m, 1'b0);
    chk({tag, "_bz_m"}, bz_m, 1'b0);
    chk({tag, "_so_l"}, so_l, 1'b0);
    chk({tag, "_ov_l"}, ov_l, 1'b0);
    chk({tag, "_bz_l"}, bz_l, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    vin = 1'b0;
    en  = 1'b0;
    din = '0;
    act = 1'b0;
    pos = 0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single frame 1011, then idle.
    cycle(1'b1, 4'b1011, 1'b1);
    repeat (NB + 1) cycle(1'b0, 4'b0000, 1'b1);

    // Single frame 1100 (LSB instance emits 0,0,1,1).
    cycle(1'b1, 4'b1100, 1'b1);
    repeat (NB + 1) cycle(1'b0, 4'b0000, 1'b1);

    // Back-to-back: 1011 then 1100 held valid until taken.
    cycle(1'b1, 4'b1011, 1'b1);
    repeat (NB) cycle(1'b1, 4'b1100, 1'b1);
    repeat (NB + 1) cycle(1'b0, 4'b0000, 1'b1);

    // Stall after the second bit; parallel_in/in_valid noise mid-frame.
    cycle(1'b1, 4'b1011, 1'b1);
    cycle(1'b1, 4'b0101, 1'b1);
    cycle(1'b1, 4'b0000, 1'b1);
    repeat (3) cycle(1'b1, 4'b1111, 1'b0);
    repeat (NB + 1) cycle(1'b0, 4'b0110, 1'b1);

    // Async reset during the third bit.
    cycle(1'b1, 4'b1011, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b0, 4'b0000, 1'b1);
    rst = 1'b1;
    #2;
    check_reset_outputs("midrst");
    act = 1'b0;
    pos = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b0, 4'b0000, 1'b1);
    cycle(1'b1, 4'b0110, 1'b1);
    repeat (NB + 1) cycle(1'b0, 4'b0000, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 9) < 6), W'($urandom()),
            ($urandom_range(0, 3) != 0));
    end
    repeat (NB + 2) cycle(1'b0, 4'b0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
